// File: rtl/keypad_scanner.sv
// ============================================================================
// keypad_scanner
// ----------------------------------------------------------------------------
// Row-scanning 4x4 matrix keypad controller with debounce.
//
// One row is driven at a time (one-hot on row_out) for SCAN_DIV clock cycles.
// The synchronized column lines are inspected once per dwell period, on the
// last cycle of the dwell (the "sample cycle"). A detected press freezes the
// scan on that row and must read back the same column pattern for
// DEBOUNCE_CNT further samples before it is accepted. A single-column press
// decodes to key_value and pulses key_valid. A multi-column press pulses
// key_error instead. Either way, the key is then held until DEBOUNCE_CNT
// consecutive all-zero samples are seen, after which scanning resumes.
//
// Parameters
//   BASE          10 or 16, selects the key legend (decimal pad or hex pad)
//   SCAN_DIV      cycles each row is driven, 4..65535
//   DEBOUNCE_CNT  consecutive matching samples to accept press/release, 1..255
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   col_in     raw column lines, active-high, asynchronous to clk
//   row_out    one-hot row drive, bit0 = top row
//   key_value  decoded value of the last accepted key
//   key_valid  one-cycle strobe, key_value has just been updated
//   key_held   level, a key is accepted and not yet released
//   key_error  one-cycle strobe, stable multi-column press rejected
// ============================================================================
module keypad_scanner #(
    parameter int BASE         = 10,
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_value,
    output logic       key_valid,
    output logic       key_held,
    output logic       key_error
);

    typedef enum logic [1:0] {
        S_SCAN,
        S_DEBOUNCE,
        S_HELD,
        S_RELEASE
    } state_t;

    // ------------------------------------------------------------------------
    // Column synchronizer
    // ------------------------------------------------------------------------
    logic [3:0] r_col_meta;
    logic [3:0] r_col_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col_meta <= 4'b0000;
            r_col_s    <= 4'b0000;
        end else begin
            r_col_meta <= col_in;
            r_col_s    <= r_col_meta;
        end
    end

    // ------------------------------------------------------------------------
    // Dwell counter: free-running 0..SCAN_DIV-1. The FSM only reacts on the
    // last count, so every row gets a full dwell of settle time before its
    // columns are judged.
    // ------------------------------------------------------------------------
    logic [15:0] r_dwell;
    logic        w_sample;

    assign w_sample = (r_dwell == 16'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dwell <= 16'd0;
        end else if (w_sample) begin
            r_dwell <= 16'd0;
        end else begin
            r_dwell <= r_dwell + 16'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Key decode
    // ------------------------------------------------------------------------
    // One-hot to index; only meaningful for one-hot inputs, which is the
    // only case in which the result is used.
    function automatic logic [1:0] f_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        case (oh)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Row-major {row,col} index to key legend.
    //   decimal pad:  1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D
    //   hex pad:      0 1 2 3 / 4 5 6 7 / 8 9 A B / C D E F
    function automatic logic [3:0] f_decode(input logic [3:0] row,
                                            input logic [3:0] col);
        logic [3:0] pos;
        logic [3:0] val;
        pos = {f_idx(row), f_idx(col)};
        val = pos;
        if (BASE != 16) begin
            case (pos)
                4'd0:    val = 4'h1;
                4'd1:    val = 4'h2;
                4'd2:    val = 4'h3;
                4'd3:    val = 4'hA;
                4'd4:    val = 4'h4;
                4'd5:    val = 4'h5;
                4'd6:    val = 4'h6;
                4'd7:    val = 4'hB;
                4'd8:    val = 4'h7;
                4'd9:    val = 4'h8;
                4'd10:   val = 4'h9;
                4'd11:   val = 4'hC;
                4'd12:   val = 4'hE;
                4'd13:   val = 4'h0;
                4'd14:   val = 4'hF;
                default: val = 4'hD;
            endcase
        end
        return val;
    endfunction

    // ------------------------------------------------------------------------
    // Scan / debounce FSM with registered outputs
    // ------------------------------------------------------------------------
    state_t     r_state;
    logic [3:0] r_row;
    logic [3:0] r_col_lat;
    logic [7:0] r_deb;
    logic [3:0] r_key_value;
    logic       r_key_valid;
    logic       r_key_held;
    logic       r_key_error;

    logic [3:0] w_row_next;
    logic       w_deb_done;
    logic       w_col_zero;

    assign w_row_next = {r_row[2:0], r_row[3]};
    assign w_col_zero = (r_col_s == 4'b0000);
    // True on the sample that would bring the count up to DEBOUNCE_CNT.
    assign w_deb_done = (({1'b0, r_deb} + 9'd1) == 9'(DEBOUNCE_CNT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_SCAN;
            r_row       <= 4'b0001;
            r_col_lat   <= 4'b0000;
            r_deb       <= 8'd0;
            r_key_value <= 4'd0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
            r_key_error <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            r_key_error <= 1'b0;

            case (r_state)
                S_SCAN: begin
                    if (w_sample) begin
                        if (w_col_zero) begin
                            r_row <= w_row_next;
                        end else begin
                            // Row stays put so the same key keeps being seen.
                            r_col_lat <= r_col_s;
                            r_deb     <= 8'd0;
                            r_state   <= S_DEBOUNCE;
                        end
                    end
                end

                S_DEBOUNCE: begin
                    if (w_sample) begin
                        if (r_col_s == r_col_lat) begin
                            if (w_deb_done) begin
                                r_deb      <= 8'd0;
                                r_state    <= S_HELD;
                                r_key_held <= 1'b1;
                                if ($onehot(r_col_lat)) begin
                                    r_key_value <= f_decode(r_row, r_col_lat);
                                    r_key_valid <= 1'b1;
                                end else begin
                                    r_key_error <= 1'b1;
                                end
                            end else begin
                                r_deb <= r_deb + 8'd1;
                            end
                        end else begin
                            // Bounce or pattern change: give up on this row.
                            r_row   <= w_row_next;
                            r_state <= S_SCAN;
                        end
                    end
                end

                S_HELD: begin
                    // Column changes while held (rolling onto another key in
                    // the same row) are deliberately ignored; only a full
                    // release is acted on.
                    if (w_sample && w_col_zero) begin
                        r_deb   <= 8'd0;
                        r_state <= S_RELEASE;
                    end
                end

                S_RELEASE: begin
                    if (w_sample) begin
                        if (w_col_zero) begin
                            if (w_deb_done) begin
                                r_deb      <= 8'd0;
                                r_row      <= w_row_next;
                                r_key_held <= 1'b0;
                                r_state    <= S_SCAN;
                            end else begin
                                r_deb <= r_deb + 8'd1;
                            end
                        end else begin
                            r_state <= S_HELD;
                        end
                    end
                end

                default: begin
                    r_state <= S_SCAN;
                end
            endcase
        end
    end

    assign row_out   = r_row;
    assign key_value = r_key_value;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;
    assign key_error = r_key_error;

endmodule

// File: tb/tb_keypad_scanner.sv
// ============================================================================
// tb_keypad_scanner
// ----------------------------------------------------------------------------
// Two scanners (decimal and hex legend) share clock, reset and a behavioural
// keypad: a pressed key at (kb_row, kb_col) only shows on col_in while its
// row is being driven. Both instances run in lockstep, so the decimal one's
// row_out drives the keypad model.
// ============================================================================
module tb_keypad_scanner;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] kb_row = 4'b0000;
    logic [3:0] kb_col = 4'b0000;
    logic [3:0] col_in;

    logic [3:0] row10, val10, row16, val16;
    logic       vld10, held10, err10, vld16, held16, err16;

    int n_cmp  = 0;
    int n_bad  = 0;
    int nvalid = 0;
    int nerr   = 0;
    int lat;

    always #5 clk = ~clk;

    assign col_in = (|(row10 & kb_row)) ? kb_col : 4'b0000;

    keypad_scanner #(.BASE(10), .SCAN_DIV(4), .DEBOUNCE_CNT(3)) u_dec (
        .clk(clk), .rst_n(rst_n), .col_in(col_in), .row_out(row10),
        .key_value(val10), .key_valid(vld10), .key_held(held10),
        .key_error(err10)
    );

    keypad_scanner #(.BASE(16), .SCAN_DIV(4), .DEBOUNCE_CNT(3)) u_hex (
        .clk(clk), .rst_n(rst_n), .col_in(col_in), .row_out(row16),
        .key_value(val16), .key_valid(vld16), .key_held(held16),
        .key_error(err16)
    );

    always @(negedge clk) begin
        if (rst_n) begin
            if (vld10) nvalid <= nvalid + 1;
            if (err10) nerr   <= nerr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Park on the first cycle of row r (dwell count 0).
    task automatic wait_row_start(input logic [3:0] r);
        int i;
        i = 0;
        while (row10 === r && i < 64) begin @(negedge clk); i++; end
        while (row10 !== r && i < 128) begin @(negedge clk); i++; end
        chk("row_reach", row10, r);
    endtask

    task automatic wait_strobe(output int cyc);
        cyc = 0;
        while (!(vld10 || err10) && cyc < 300) begin @(negedge clk); cyc++; end
        chk("strobe_seen", 32'(vld10 || err10), 1);
    endtask

    task automatic press(input logic [3:0] r, input logic [3:0] c,
                         output int cyc);
        wait_row_start(r);
        kb_row = r;
        kb_col = c;
        wait_strobe(cyc);
    endtask

    task automatic release_key();
        int i;
        kb_col = 4'b0000;
        repeat (8) @(negedge clk);
        chk("held_during_release", held10, 1);
        i = 0;
        while (held10 && i < 100) begin @(negedge clk); i++; end
        chk("released", held10, 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        // ---------------- reset values
        repeat (3) @(negedge clk);
        chk("rst_row", row10, 4'b0001);
        chk("rst_val", val10, 0);
        chk("rst_vld", vld10, 0);
        chk("rst_held", held10, 0);
        chk("rst_err", err10, 0);
        chk("rst_val16", val16, 0);
        rst_n = 1'b1;

        // ---------------- idle rotation, 4 cycles per row
        for (int i = 0; i < 20; i++) begin
            chk("idle_row", row10, 32'(4'b0001 << ((i / 4) % 4)));
            @(negedge clk);
        end
        chk("idle_nvalid", nvalid, 0);
        chk("idle_nerr", nerr, 0);

        // ---------------- single press row 0010 col 0010 -> 5
        press(4'b0010, 4'b0010, lat);
        chk("lat_valid", lat, 16);
        chk("val_5", val10, 5);
        chk("val16_5", val16, 5);
        repeat (40) @(negedge clk);
        chk("held_5", held10, 1);
        chk("nvalid_1", nvalid, 1);
        release_key();
        chk("nvalid_1_after_rel", nvalid, 1);

        // ---------------- bouncing press in row 0001 col 0010 -> 2
        wait_row_start(4'b0001);
        kb_row = 4'b0001;
        kb_col = 4'b0010;
        repeat (10) begin
            repeat (3) @(negedge clk);
            kb_col = kb_col ^ 4'b0010;
        end
        kb_col = 4'b0010;
        wait_strobe(lat);
        chk("bounce_vld", vld10, 1);
        chk("val_2", val10, 2);
        chk("val16_1", val16, 1);
        release_key();
        chk("nvalid_2", nvalid, 2);

        // ---------------- multi-column press row 1000 col 0101 -> error
        press(4'b1000, 4'b0101, lat);
        chk("err_pulse", err10, 1);
        chk("err_no_vld", vld10, 0);
        @(negedge clk);
        chk("err_one_cycle", err10, 0);
        chk("err_val_kept", val10, 2);
        chk("err_held", held10, 1);
        release_key();
        chk("nerr_1", nerr, 1);
        chk("nvalid_2_err", nvalid, 2);

        // ---------------- corner keys, both legends
        press(4'b1000, 4'b1000, lat);
        chk("val_D", val10, 13);
        chk("val16_F", val16, 15);
        release_key();
        press(4'b0001, 4'b0001, lat);
        chk("val_1", val10, 1);
        chk("val16_0", val16, 0);
        release_key();
        chk("nvalid_4", nvalid, 4);

        // ---------------- reset while held
        press(4'b0100, 4'b0001, lat);
        chk("val_7", val10, 7);
        chk("val16_8", val16, 8);
        repeat (5) @(negedge clk);
        chk("held_pre_rst", held10, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_row", row10, 4'b0001);
        chk("arst_held", held10, 0);
        chk("arst_val", val10, 0);
        chk("arst_val16", val16, 0);
        repeat (3) @(negedge clk);
        kb_col = 4'b0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("post_rst_row", row10, 4'b0001);
        repeat (60) @(negedge clk);
        chk("post_rst_nvalid", nvalid, 5);
        chk("post_rst_held", held10, 0);
        chk("post_rst_val", val10, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
